// File: rtl/cnn_pkg.sv
// Types and helpers shared by the CNN layer datapath blocks.
package cnn_pkg;

   localparam int unsigned DATA_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } rd_state_e;

   // Side length of a feature map after adding a zero border of width pad.
   function automatic int unsigned psize(input int unsigned fm, input int unsigned pad);
      return fm + 2 * pad;
   endfunction

endpackage

// File: rtl/stream_fifo.sv
// Four-entry synchronous FIFO with occupancy count; the head entry is presented
// straight from storage so readers see it the cycle after it is written.
module stream_fifo #(
   parameter int unsigned WIDTH = 18
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [2:0]       count_o
);

   localparam int unsigned DEPTH = 4;
   localparam int unsigned PW    = 2;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [2:0]       count_q, count_d;
   logic             do_pop;

   // Next storage, pointer and occupancy; pops of an empty FIFO are dropped.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      do_pop   = pop_i && (count_q != 3'd0);
      if (push_i) begin
         mem_d[wr_ptr_q] = wdata_i;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push_i, do_pop})
         2'b10:   count_d = count_q + 3'd1;
         2'b01:   count_d = count_q - 3'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fm_stream_reader.sv
// Drains one stored feature map from the layer buffer and re-emits it as a
// zero-padded raster stream; buffer reads are only issued with a FIFO slot reserved.
module fm_stream_reader #(
   parameter int unsigned DATA_WIDTH = cnn_pkg::DATA_WIDTH,
   parameter int unsigned FM_SIZE    = 5,
   parameter int unsigned PAD        = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  buf_re,
   input  logic [DATA_WIDTH-1:0] buf_d,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_sol,
   output logic                  m_last
);

   import cnn_pkg::*;

   localparam int unsigned PSIZE = psize(FM_SIZE, PAD);
   localparam int unsigned CW    = (PSIZE > 1) ? $clog2(PSIZE) : 1;
   localparam int unsigned FW    = DATA_WIDTH + 2;
   localparam logic [CW-1:0] LAST_POS = CW'(PSIZE - 1);

   rd_state_e state_q, state_d;

   logic [CW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          s1_valid_q, s1_valid_d;
   logic          s1_pad_q,   s1_pad_d;
   logic          s1_sol_q,   s1_sol_d;
   logic          s1_last_q,  s1_last_d;

   int                    row_off, col_off;
   logic                  interior;
   logic                  at_end;
   logic                  room;
   logic                  issue;
   logic                  pop;
   logic                  head_last;
   logic [DATA_WIDTH-1:0] push_data;
   logic [FW-1:0]         fifo_wdata;
   logic [FW-1:0]         fifo_rdata;
   logic [2:0]            fifo_count;

   // Position classification and issue gating against FIFO occupancy plus the in-flight word.
   always_comb begin
      row_off  = int'(row_q) - int'(PAD);
      col_off  = int'(col_q) - int'(PAD);
      interior = (row_off >= 0) && (row_off < int'(FM_SIZE)) &&
                 (col_off >= 0) && (col_off < int'(FM_SIZE));
      at_end   = (row_q == LAST_POS) && (col_q == LAST_POS);
      room     = (({1'b0, fifo_count} + {3'b000, s1_valid_q}) < 4'd4);
      issue    = (state_q == ISSUE) && room;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)             state_d = ISSUE;
         ISSUE:   if (issue && at_end)   state_d = DRAIN;
         DRAIN:   if (pop && head_last)  state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   always_comb begin
      busy   = (state_q != IDLE);
      buf_re = issue && interior;
      done   = (state_q == DRAIN) && pop && head_last;
   end

   // Raster walk (col fastest) and the single stage that lines pads up with read data.
   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (state_q == IDLE) begin
         row_d = '0;
         col_d = '0;
      end else if (issue) begin
         if (col_q == LAST_POS) begin
            col_d = '0;
            row_d = (row_q == LAST_POS) ? '0 : row_q + CW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
      s1_valid_d = issue;
      s1_pad_d   = !interior;
      s1_sol_d   = (col_q == '0);
      s1_last_d  = at_end;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_q      <= '0;
         col_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_pad_q   <= 1'b0;
         s1_sol_q   <= 1'b0;
         s1_last_q  <= 1'b0;
      end else begin
         row_q      <= row_d;
         col_q      <= col_d;
         s1_valid_q <= s1_valid_d;
         s1_pad_q   <= s1_pad_d;
         s1_sol_q   <= s1_sol_d;
         s1_last_q  <= s1_last_d;
      end
   end

   // Read data arrives the cycle after buf_re, alongside its stage-1 tag.
   always_comb begin
      push_data  = s1_pad_q ? DATA_WIDTH'(0) : buf_d;
      fifo_wdata = {push_data, s1_sol_q, s1_last_q};
   end

   stream_fifo #(
      .WIDTH (FW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (s1_valid_q),
      .wdata_i (fifo_wdata),
      .pop_i   (pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count)
   );

   // Head unpack; payload is forced to zero whenever no word is presented.
   always_comb begin
      m_valid   = (fifo_count != 3'd0);
      pop       = m_valid && m_ready;
      head_last = fifo_rdata[0];
      m_data    = m_valid ? fifo_rdata[FW-1:2] : DATA_WIDTH'(0);
      m_sol     = m_valid && fifo_rdata[1];
      m_last    = m_valid && fifo_rdata[0];
   end

endmodule

// File: tb/tb_fm_stream_reader.sv
// Directed bench for fm_stream_reader: padded frame content, backpressure, restart and reset.
`timescale 1ns/1ps
module tb_fm_stream_reader;

   localparam int DW = 16;
   localparam int FM = 5;
   localparam int PS = 7;
   localparam int NW = PS * PS;
   localparam int N0 = FM * FM;

   typedef struct {
      int   idx;
      int   data;
      logic sol;
      logic last;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n, start, start0, m_ready;
   logic busy, done, buf_re, m_valid, m_sol, m_last;
   logic [DW-1:0] buf_d, m_data;
   logic busy0, done0, buf_re0, m_valid0, m_sol0, m_last0;
   logic [DW-1:0] buf_d0, m_data0;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int base = 0;
   logic rand_rdy = 1'b0;

   logic [DW-1:0] mem [N0];
   int rd_ptr, rd_ptr0;

   logic [DW-1:0] q_data [$];
   logic          q_sol  [$];
   logic          q_last [$];
   int re_cnt, done_cnt, done_cyc, first_cyc;
   logic stall_q = 1'b0;
   logic [DW+1:0] held;

   logic [DW-1:0] q0 [$];
   int re0_cnt = 0, re0_first = 0, re0_last = 0, done0_cnt = 0, done0_cyc = 0, sol0_cnt = 0;

   fm_stream_reader #(.DATA_WIDTH(DW), .FM_SIZE(FM), .PAD(1)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .buf_re(buf_re), .buf_d(buf_d), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_sol(m_sol), .m_last(m_last));

   fm_stream_reader #(.DATA_WIDTH(DW), .FM_SIZE(FM), .PAD(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .busy(busy0), .done(done0),
      .buf_re(buf_re0), .buf_d(buf_d0), .m_valid(m_valid0), .m_ready(m_ready),
      .m_data(m_data0), .m_sol(m_sol0), .m_last(m_last0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Buffer models: registered read, zero when not reading, pointer wraps after FM*FM reads.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= 0; buf_d <= '0;
      end else if (buf_re) begin
         buf_d <= mem[rd_ptr]; rd_ptr <= (rd_ptr == N0 - 1) ? 0 : rd_ptr + 1;
      end else begin
         buf_d <= '0;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr0 <= 0; buf_d0 <= '0;
      end else if (buf_re0) begin
         buf_d0 <= mem[rd_ptr0]; rd_ptr0 <= (rd_ptr0 == N0 - 1) ? 0 : rd_ptr0 + 1;
      end else begin
         buf_d0 <= '0;
      end
   end

   always @(posedge clk) begin
      if (rand_rdy) begin
         #1 m_ready = 1'($urandom_range(0, 1));
      end
   end

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endfunction

   // Output monitor: captures handshakes, checks hold-while-stalled, done alignment, no overflow.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall_q = 1'b0;
      end else begin
         if (buf_re) re_cnt++;
         if (stall_q) chk("stall_hold", 32'({m_valid, m_data, m_sol, m_last}), 32'({1'b1, held}));
         if (m_valid && m_ready) begin
            if (q_data.size() == 0) first_cyc = cyc;
            q_data.push_back(m_data); q_sol.push_back(m_sol); q_last.push_back(m_last);
         end
         if (done || (m_valid && m_ready && m_last)) begin
            chk("done_on_last", 32'(done), 32'(m_valid && m_ready && m_last));
            if (done) begin done_cnt++; done_cyc = cyc; end
         end
         if (dut.u_fifo.push_i)
            chk("no_overflow", 32'((dut.u_fifo.count_q == 3'd4) && !dut.u_fifo.pop_i), 32'd0);
         stall_q = m_valid && !m_ready;
         held    = {m_data, m_sol, m_last};
         if (rst_n && buf_re0) begin
            if (re0_cnt == 0) re0_first = cyc;
            re0_last = cyc; re0_cnt++;
         end
         if (m_valid0 && m_ready) begin
            q0.push_back(m_data0);
            if (m_sol0) sol0_cnt++;
         end
         if (done0) begin
            done0_cnt++; done0_cyc = cyc;
            chk("pad0_last_with_done", 32'(m_last0), 32'd1);
         end
      end
   end

   task automatic clear_mon();
      q_data.delete(); q_sol.delete(); q_last.delete();
      re_cnt = 0; done_cnt = 0; done_cyc = 0; first_cyc = 0;
   endtask

   task automatic pulse_start(output int c0);
      start = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int i = 0;
      while (done_cnt == 0 && i < 2000) begin
         @(posedge clk); i++;
      end
      #1;
      chk({tag, "_done_seen"}, 32'(done_cnt), 32'd1);
   endtask

   task automatic check_frame(input string tag, input int b);
      int r, c;
      logic [DW-1:0] e;
      chk({tag, "_nwords"}, 32'(q_data.size()), 32'(NW));
      for (int k = 0; k < NW && k < q_data.size(); k++) begin
         r = k / PS; c = k % PS;
         e = (r >= 1 && r <= FM && c >= 1 && c <= FM) ? DW'(b + (r - 1) * FM + c) : '0;
         chk($sformatf("%s_data[%0d]", tag, k), 32'(q_data[k]), 32'(e));
         chk($sformatf("%s_sol[%0d]", tag, k), 32'(q_sol[k]), 32'(c == 0));
         chk($sformatf("%s_last[%0d]", tag, k), 32'(q_last[k]), 32'(k == NW - 1));
      end
      chk({tag, "_reads"}, 32'(re_cnt), 32'(N0));
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_buf_re"}, 32'(buf_re), 32'd0);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_m_data"}, 32'(m_data), 32'd0);
      chk({tag, "_m_sol"}, 32'(m_sol), 32'd0);
      chk({tag, "_m_last"}, 32'(m_last), 32'd0);
   endtask

   initial begin
      vec_t tbl [10];
      int c0, cx, i;
      tbl[0] = '{0,  0,  1'b1, 1'b0};
      tbl[1] = '{7,  0,  1'b1, 1'b0};
      tbl[2] = '{8,  1,  1'b0, 1'b0};
      tbl[3] = '{12, 5,  1'b0, 1'b0};
      tbl[4] = '{13, 0,  1'b0, 1'b0};
      tbl[5] = '{24, 13, 1'b0, 1'b0};
      tbl[6] = '{36, 21, 1'b0, 1'b0};
      tbl[7] = '{40, 25, 1'b0, 1'b0};
      tbl[8] = '{42, 0,  1'b1, 1'b0};
      tbl[9] = '{48, 0,  1'b0, 1'b1};

      for (int k = 0; k < N0; k++) mem[k] = DW'(k + 1);
      rst_n = 1'b0; start = 1'b0; start0 = 1'b0; m_ready = 1'b1;
      #12;
      check_idle_outputs("reset");
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Full frame, m_ready high
      clear_mon();
      pulse_start(c0);
      wait_done("t1");
      check_frame("t1", 0);
      chk("t1_first_word_cycle", 32'(first_cyc - c0), 32'd2);
      chk("t1_frame_cycles", 32'(done_cyc - c0 + 1), 32'(NW + 2));
      chk("t1_busy_after_done", 32'(busy), 32'd0);
      for (int k = 0; k < 10; k++) begin
         if (tbl[k].idx < q_data.size()) begin
            chk($sformatf("tbl_data[%0d]", tbl[k].idx), 32'(q_data[tbl[k].idx]), 32'(tbl[k].data));
            chk($sformatf("tbl_sol[%0d]", tbl[k].idx), 32'(q_sol[tbl[k].idx]), 32'(tbl[k].sol));
            chk($sformatf("tbl_last[%0d]", tbl[k].idx), 32'(q_last[tbl[k].idx]), 32'(tbl[k].last));
         end
      end

      // Random backpressure
      clear_mon();
      rand_rdy = 1'b1;
      pulse_start(c0);
      wait_done("t2");
      rand_rdy = 1'b0;
      @(posedge clk); #2 m_ready = 1'b1;
      check_frame("t2", 0);

      // Downstream stalled for 20 cycles right after start
      @(posedge clk); #1;
      clear_mon();
      m_ready = 1'b0;
      pulse_start(c0);
      repeat (20) @(posedge clk);
      #1;
      chk("t3_no_reads", 32'(re_cnt), 32'd0);
      chk("t3_no_words", 32'(q_data.size()), 32'd0);
      chk("t3_fifo_full", 32'(dut.u_fifo.count_q), 32'd4);
      chk("t3_head_valid", 32'(m_valid), 32'd1);
      chk("t3_head_sol", 32'(m_sol), 32'd1);
      m_ready = 1'b1;
      wait_done("t3");
      check_frame("t3", 0);

      // Start re-pulsed mid-frame is ignored
      clear_mon();
      pulse_start(c0);
      repeat (10) @(posedge clk);
      #1 pulse_start(cx);
      wait_done("t4");
      repeat (60) @(posedge clk);
      #1;
      chk("t4_single_done", 32'(done_cnt), 32'd1);
      check_frame("t4", 0);

      // Back-to-back frames: restart in the cycle after done
      clear_mon();
      pulse_start(c0);
      wait_done("t4b");
      check_frame("t4b", 0);
      clear_mon();
      pulse_start(c0);
      wait_done("t4c");
      check_frame("t4c", 0);
      chk("t4c_frame_cycles", 32'(done_cyc - c0 + 1), 32'(NW + 2));

      // Reset at word 20, then a fresh frame from a reloaded buffer
      clear_mon();
      pulse_start(c0);
      i = 0;
      while (q_data.size() < 20 && i < 500) begin
         @(negedge clk); i++;
      end
      chk("t5_reached_word20", 32'(q_data.size() >= 20), 32'd1);
      #1 rst_n = 1'b0;
      #1 check_idle_outputs("midreset");
      base = 100;
      for (int k = 0; k < N0; k++) mem[k] = DW'(base + k + 1);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      pulse_start(c0);
      wait_done("t5");
      check_frame("t5", base);

      // PAD = 0 instance
      @(posedge clk); #1;
      start0 = 1'b1;
      @(posedge clk); #1;
      c0 = cyc; start0 = 1'b0;
      i = 0;
      while (done0_cnt == 0 && i < 500) begin
         @(posedge clk); i++;
      end
      #1;
      chk("pad0_done_seen", 32'(done0_cnt), 32'd1);
      chk("pad0_nwords", 32'(q0.size()), 32'(N0));
      for (int k = 0; k < N0 && k < q0.size(); k++)
         chk($sformatf("pad0_data[%0d]", k), 32'(q0[k]), 32'(base + k + 1));
      chk("pad0_reads", 32'(re0_cnt), 32'(N0));
      chk("pad0_first_read", 32'(re0_first - c0), 32'd0);
      chk("pad0_read_span", 32'(re0_last - re0_first), 32'(N0 - 1));
      chk("pad0_sol_count", 32'(sol0_cnt), 32'(FM));
      chk("pad0_frame_cycles", 32'(done0_cyc - c0 + 1), 32'(N0 + 2));
      chk("pad0_busy_after", 32'(busy0), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fm_stream_reader.md
# fm_stream_reader

Read-side controller for the layer output feature-map buffer. On `start` it drains one FM_SIZE×FM_SIZE frame from the buffer's read port (`re`/`d_out`, 1-cycle read latency, output forced to 0 when `re` is low). It re-emits that frame as a zero-padded raster stream of PSIZE×PSIZE words on a valid/ready interface feeding the next convolution layer. It owns all buffer read timing, so the buffer itself needs no stall capability.

## Interface
Parameters:
- DATA_WIDTH, 16, word width, equal to the buffer's width
- FM_SIZE, 5, side of the stored feature map (the buffer's DEPTH)
- PAD, 1, zero border added for the next layer; PSIZE = FM_SIZE + 2*PAD

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle frame request; ignored while busy
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse with the final handshake
- buf_re  out  1  buffer read enable
- buf_d  in  DATA_WIDTH  buffer read data, valid the cycle after buf_re
- m_valid  out  1  output word valid
- m_ready  in  1  downstream ready
- m_data  out  DATA_WIDTH  padded pixel
- m_sol  out  1  first word of a padded row (col == 0)
- m_last  out  1  final word of the frame (row == col == PSIZE-1)

## Operation
- FSM states:
  - IDLE: waits for start.
  - ISSUE: walks positions (row, col) in raster order, col fastest, range 0..PSIZE-1.
  - DRAIN: last position issued; waits for the FIFO to empty.
  - Transitions: IDLE→ISSUE on start; ISSUE→DRAIN when position (PSIZE-1, PSIZE-1) issues; DRAIN→IDLE on the final handshake, with done pulsed in the same cycle.
- Issue rule: one position per cycle while `fifo_count + inflight < 4`.
  - inflight is the 1-bit stage-1 valid.
  - fifo_count is the registered occupancy of the 4-entry output FIFO.
- Interior position (PAD ≤ row,col < PAD+FM_SIZE):
  - buf_re = 1 for that cycle.
  - Stage 1 captures buf_d on the next edge.
- Pad position:
  - buf_re = 0.
  - Stage 1 carries a zero word.
  - Pads and reads share the same 1-cycle path, so ordering is preserved.
- Stage 1 pushes {data, sol, last} into the FIFO. The FIFO head drives the m_* outputs. A pop happens when m_valid & m_ready.
- Exactly FM_SIZE² reads are issued per frame. The buffer read pointer therefore returns to 0 at frame end; no rewind signal exists.
- Counters are $clog2(PSIZE) bits wide and compare against PSIZE-1 (no power-of-two assumption). fifo_count is 3 bits (0..4).
- start while busy: ignored. A new start in the cycle after done is accepted.

## Timing
- Reset values: busy=0, done=0, buf_re=0, m_valid=0, m_data=0, m_sol=0, m_last=0. Counters, FIFO pointers and stage 1 are cleared; state=IDLE.
- start sampled at edge E0:
  - First issue happens in the cycle after E0.
  - Stage 1 loads at E1.
  - FIFO holds the word after E2; m_valid rises 2 cycles after E0.
- m_ready held high: one word per cycle, no bubbles. A frame completes PSIZE² + 2 cycles after E0.
- m_ready low: issue stops once count + inflight reaches 4. No word is lost, because no read is issued without a guaranteed FIFO slot.
- m_valid/m_data/m_sol/m_last stay stable while m_valid & !m_ready.
- Simultaneous push and pop: count unchanged. A push into a full FIFO is impossible by construction; the bench asserts this.
- Reset mid-frame clears all state immediately. The buffer shares rst_n, so its pointers also return to 0.

## Structure
- Shared package cnn_pkg holds:
  - DATA_WIDTH default.
  - padded-size function psize(fm, pad).
  - FSM state enum {IDLE, ISSUE, DRAIN}.
- One sub-module: `stream_fifo`, a 4-entry synchronous FIFO of width DATA_WIDTH+2 with count output.

## Test plan
- Buffer model preloaded 1..25, FM_SIZE=5, PAD=1, m_ready=1:
  - 49 words out.
  - Row 0 all 0; row 1 = 0,1,2,3,4,5,0; row 5 = 0,21..25,0; row 6 all 0.
  - m_sol on words 0,7,…,42; m_last and done on word 48.
  - Exactly 25 buf_re pulses.
- m_ready random 50% duty: same sequence; FIFO never overflows; outputs stable while stalled.
- m_ready low for 20 cycles after start: at most 4 positions issued, then buf_re stays 0; on release the stream resumes with no gaps or duplicates.
- start pulsed again mid-frame: ignored; exactly one done; second frame started after done reproduces the data (pointer wrap).
- rst_n asserted at word 20: all outputs 0 immediately. A fresh start plus reloaded buffer yields the full correct 49-word frame.
- PAD=0: 25 words equal to 1..25, buf_re every issue cycle, frame done 27 cycles after start with m_ready=1.
